// File: rtl/mouse_poller.sv
// Periodic reader of the PS/2 mouse register block: snapshots status/X/Y,
// re-reads X to detect a torn packet, and publishes the result with edge pulses.
module mouse_poller #(
    parameter int unsigned POLL_CYCLES = 50000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mouse_ack,
    input  logic [7:0] mouse_data,
    output logic [1:0] mouse_addr,
    output logic       mouse_cs,
    output logic [2:0] btn,
    output logic [7:0] pos_x,
    output logic [7:0] pos_y,
    output logic       upd,
    output logic [2:0] press,
    output logic       moved,
    output logic       torn
);

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        WAIT_ACK,
        IDLE,
        RD_S,
        RD_X,
        RD_Y,
        RD_X2,
        PUBLISH
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 torn_pending;
    logic [2:0]           s_cap;
    logic [7:0]           x_cap;
    logic [7:0]           y_cap;

    // Register select is a pure decode of the read states
    always_comb begin
        mouse_addr = 2'd0;
        mouse_cs   = 1'b0;
        case (state)
            RD_S:    begin mouse_addr = 2'd0; mouse_cs = 1'b1; end
            RD_X:    begin mouse_addr = 2'd1; mouse_cs = 1'b1; end
            RD_Y:    begin mouse_addr = 2'd2; mouse_cs = 1'b1; end
            RD_X2:   begin mouse_addr = 2'd1; mouse_cs = 1'b1; end
            default: begin mouse_addr = 2'd0; mouse_cs = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= WAIT_ACK;
            timer        <= '0;
            retry_cnt    <= '0;
            torn_pending <= 1'b0;
            s_cap        <= '0;
            x_cap        <= '0;
            y_cap        <= '0;
            btn          <= '0;
            pos_x        <= 8'h3F;
            pos_y        <= 8'hEF;
            upd          <= 1'b0;
            press        <= '0;
            moved        <= 1'b0;
            torn         <= 1'b0;
        end else begin
            upd   <= 1'b0;
            press <= '0;
            moved <= 1'b0;
            torn  <= 1'b0;

            // Losing the ack abandons any snapshot in flight; published values stay
            if (state != WAIT_ACK && !mouse_ack) begin
                state        <= WAIT_ACK;
                retry_cnt    <= '0;
                torn_pending <= 1'b0;
            end else begin
                case (state)
                    WAIT_ACK: begin
                        if (mouse_ack) begin
                            state <= IDLE;
                            timer <= TIMER_RELOAD;
                        end
                    end
                    IDLE: begin
                        if (timer == '0) begin
                            state     <= RD_S;
                            retry_cnt <= '0;
                        end else begin
                            timer <= timer - TIMER_W'(1);
                        end
                    end
                    RD_S: begin
                        s_cap <= mouse_data[2:0];
                        state <= RD_X;
                    end
                    RD_X: begin
                        x_cap <= mouse_data;
                        state <= RD_Y;
                    end
                    RD_Y: begin
                        y_cap <= mouse_data;
                        state <= RD_X2;
                    end
                    // X moved under us: retry X/Y, or give up and flag the snapshot torn
                    RD_X2: begin
                        if (mouse_data == x_cap) begin
                            state <= PUBLISH;
                        end else if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            state     <= RD_X;
                        end else begin
                            x_cap        <= mouse_data;
                            torn_pending <= 1'b1;
                            state        <= PUBLISH;
                        end
                    end
                    PUBLISH: begin
                        btn          <= s_cap;
                        pos_x        <= x_cap;
                        pos_y        <= y_cap;
                        upd          <= 1'b1;
                        press        <= s_cap & ~btn;
                        moved        <= (x_cap != pos_x) || (y_cap != pos_y);
                        torn         <= torn_pending;
                        torn_pending <= 1'b0;
                        state        <= IDLE;
                        timer        <= TIMER_RELOAD;
                    end
                    default: state <= WAIT_ACK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mouse_poller.sv
// Directed bench for mouse_poller: a snapshot-level reference model checked every
// cycle, plus literal expectations for latency, bus order and published values.
module tb_mouse_poller;

    localparam int unsigned POLL    = 4;
    localparam int unsigned RETRIES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       mouse_ack;
    logic [7:0] mouse_data;
    logic [1:0] mouse_addr;
    logic       mouse_cs;
    logic [2:0] btn;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic       upd;
    logic [2:0] press;
    logic       moved;
    logic       torn;

    mouse_poller #(
        .POLL_CYCLES (POLL),
        .MAX_RETRY   (RETRIES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mouse_ack  (mouse_ack),
        .mouse_data (mouse_data),
        .mouse_addr (mouse_addr),
        .mouse_cs   (mouse_cs),
        .btn        (btn),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .upd        (upd),
        .press      (press),
        .moved      (moved),
        .torn       (torn)
    );

    always #5 clk = ~clk;

    // Mouse register file; X can be made to change after each X read
    logic [7:0] st_reg, x_a, x_b, y_reg, xv;
    int         x_mode, x_base, xidx;
    int         xreads = 0;

    always @(posedge clk) if (mouse_cs && mouse_addr == 2'd1) xreads <= xreads + 1;

    always_comb begin
        xidx = xreads - x_base;
        case (x_mode)
            1:       xv = (xidx >= 1) ? x_b : x_a;
            2:       xv = xidx[0] ? x_b : x_a;
            default: xv = x_a;
        endcase
        case (mouse_addr)
            2'd0:    mouse_data = st_reg;
            2'd1:    mouse_data = xv;
            2'd2:    mouse_data = y_reg;
            default: mouse_data = 8'h00;
        endcase
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: published snapshot plus the schedule of the poll in flight
    bit         armed;
    int         due, k, pub_at, groups;
    logic [2:0] m_s, p_btn;
    logic [7:0] m_x, m_y, p_x, p_y;
    bit         m_torn;
    logic       s_cs, s_upd, s_moved, s_torn;
    logic [1:0] s_addr;
    logic [2:0] s_press;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        logic [1:0] e_addr;
        s_cs = mouse_cs; s_addr = mouse_addr; s_upd = upd;
        s_press = press; s_moved = moved; s_torn = torn;
        if (!rst) begin
            armed = 0; k = -1; pub_at = -1;
            p_btn = 3'b000; p_x = 8'h3F; p_y = 8'hEF;
            chk("rst_cs", 32'(mouse_cs), 32'(0));
            chk("rst_pulses", 32'({upd, press, moved, torn}), 32'(0));
            chk("rst_btn", 32'(btn), 32'(p_btn));
            chk("rst_pos", 32'({pos_x, pos_y}), 32'({p_x, p_y}));
            return;
        end
        if (armed && k < 0 && cyc == due) begin
            k = 0; groups = 0; m_torn = 0;
        end
        e_addr = (k <= 0) ? 2'd0 : (((k - 1) % 3 == 1) ? 2'd2 : 2'd1);
        chk("cs", 32'(mouse_cs), 32'(k >= 0));
        chk("addr", 32'(mouse_addr), 32'(e_addr));
        if (cyc == pub_at) begin
            chk("upd", 32'(upd), 32'(1));
            chk("press", 32'(press), 32'(m_s & ~p_btn));
            chk("moved", 32'(moved), 32'((m_x != p_x) || (m_y != p_y)));
            chk("torn", 32'(torn), 32'(m_torn));
            p_btn = m_s; p_x = m_x; p_y = m_y;
            pub_at = -1;
            due = cyc + POLL;
        end else begin
            chk("idle_pulses", 32'({upd, press, moved, torn}), 32'(0));
        end
        chk("btn", 32'(btn), 32'(p_btn));
        chk("pos", 32'({pos_x, pos_y}), 32'({p_x, p_y}));
        if (k == 0) begin
            m_s = mouse_data[2:0];
            k = 1;
        end else if (k > 0) begin
            case ((k - 1) % 3)
                0: begin m_x = mouse_data; k++; end
                1: begin m_y = mouse_data; k++; end
                default: begin
                    groups++;
                    if (mouse_data == m_x) begin
                        pub_at = cyc + 2; k = -1;
                    end else if (groups > int'(RETRIES)) begin
                        m_x = mouse_data; m_torn = 1;
                        pub_at = cyc + 2; k = -1;
                    end else begin
                        k++;
                    end
                end
            endcase
        end
        if (armed && !mouse_ack) begin
            armed = 0; k = -1; pub_at = -1;
        end else if (!armed && mouse_ack) begin
            armed = 1; due = cyc + 1 + POLL;
        end
    endtask

    // One clock: sample at the falling edge, return just after the next rising edge
    task automatic step();
        @(negedge clk);
        cyc++;
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_upd(input int limit, output int n, output int seq);
        n = 0; seq = 0;
        do begin
            step();
            n++;
            if (s_cs) seq = seq * 4 + int'(s_addr);
        end while (!s_upd && n < limit);
        chk("upd_seen", 32'(s_upd), 32'(1));
    endtask

    int n, seq;

    initial begin
        rst = 1'b1; mouse_ack = 1'b0;
        st_reg = 8'h00; x_a = 8'h00; x_b = 8'h00; y_reg = 8'h00;
        x_mode = 0; x_base = 0;
        armed = 0; k = -1; pub_at = -1; due = 0; groups = 0;
        m_s = '0; m_x = '0; m_y = '0; m_torn = 0;
        p_btn = '0; p_x = 8'h3F; p_y = 8'hEF;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b1;
        step(); step();

        // First poll compares against the reset centre; upper status bits ignored
        st_reg = 8'hC9; x_a = 8'h50; y_reg = 8'h60; mouse_ack = 1'b1;
        wait_upd(40, n, seq);
        chk("lat_first", 32'(n), 32'(11));
        chk("seq_first", 32'(seq), 32'h19);
        chk("press_first", 32'(s_press), 32'(3'b001));
        chk("moved_first", 32'(s_moved), 32'(1));
        chk("pos_first", 32'({btn, pos_x, pos_y}), 32'({3'b001, 8'h50, 8'h60}));

        // Unchanged data: no press, no movement
        wait_upd(40, n, seq);
        chk("period", 32'(n), 32'(9));
        chk("press_same", 32'({s_press, s_moved}), 32'(0));

        // X changes once between reads: one retry
        st_reg = 8'h05; x_b = 8'h51; x_base = xreads; x_mode = 1;
        wait_upd(40, n, seq);
        chk("period_retry1", 32'(n), 32'(12));
        chk("seq_retry1", 32'(seq), 32'h659);
        chk("x_retry1", 32'(pos_x), 32'(8'h51));
        chk("torn_retry1", 32'(s_torn), 32'(0));
        chk("press_retry1", 32'(s_press), 32'(3'b100));

        // X toggles on every read: retries exhausted, torn snapshot
        st_reg = 8'h06; x_a = 8'h51; x_b = 8'h70; y_reg = 8'h61;
        x_base = xreads; x_mode = 2;
        wait_upd(60, n, seq);
        chk("period_torn", 32'(n), 32'(15));
        chk("seq_torn", 32'(seq), 32'h19659);
        chk("torn_torn", 32'(s_torn), 32'(1));
        chk("x_torn", 32'({pos_x, pos_y}), 32'({8'h70, 8'h61}));
        chk("press_torn", 32'(s_press), 32'(3'b010));
        x_mode = 0; x_a = 8'h70;

        // Drop ack during RD_Y
        repeat (5) step();
        mouse_ack = 1'b0;
        step();
        chk("in_rd_y", 32'({s_cs, s_addr}), 32'({1'b1, 2'd2}));
        step();
        chk("cs_after_drop", 32'(s_cs), 32'(0));
        repeat (6) step();
        chk("held_after_drop", 32'({btn, pos_x, pos_y}), 32'({3'b110, 8'h70, 8'h61}));
        y_reg = 8'h62; mouse_ack = 1'b1;
        wait_upd(40, n, seq);
        chk("lat_reack", 32'(n), 32'(11));
        chk("seq_reack", 32'(seq), 32'h19);
        chk("moved_reack", 32'({s_press, s_moved}), 32'({3'b000, 1'b1}));

        // Reset in the middle of RD_X
        repeat (4) step();
        chk("in_rd_x", 32'({mouse_cs, mouse_addr}), 32'({1'b1, 2'd1}));
        rst = 1'b0; mouse_ack = 1'b0;
        #1;
        chk("async_rst_out", 32'({btn, pos_x, pos_y}), 32'({3'b000, 8'h3F, 8'hEF}));
        chk("async_rst_bus", 32'({mouse_cs, upd, press, moved, torn}), 32'(0));
        repeat (3) step();
        rst = 1'b1;
        repeat (4) step();
        mouse_ack = 1'b1;
        wait_upd(40, n, seq);
        chk("lat_after_rst", 32'(n), 32'(11));
        chk("press_after_rst", 32'({s_press, s_moved, s_torn}), 32'({3'b110, 1'b1, 1'b0}));
        chk("pos_after_rst", 32'({btn, pos_x, pos_y}), 32'({3'b110, 8'h70, 8'h62}));
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
